// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for the 8x16 register file: latches one instruction per
// start handshake and steps through register reads, execute and writeback.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// WAIT      | idle, w=1; accept instr into IR when s=1
// DECODE    | classify IR, no strobes
// ERR       | illegal opcode, err pulse for one cycle
// GET_A     | read Rn into A
// GET_B     | read Rm into B
// EXEC      | shifter/ALU step; loadc, or loads for CMP
// WRITE_RES | write C into Rd
// WRITE_IMM | write sximm8 into Rn
module regfile_sequencer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s,
  input  logic [15:0]       instr,
  output logic              w,
  output logic              err,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        aluop,
  output logic [DATA_W-1:0] sximm8
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_ERR       = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_EXEC      = 3'd5,
    S_WRITE_RES = 3'd6,
    S_WRITE_IMM = 3'd7
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_MVN = 2'b11;

  state_t      state, state_nxt;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == ALU_CMP);
  assign is_mvn     = is_alu && (op == ALU_MVN);

  assign sximm8 = DATA_W'(signed'(ir[7:0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_WAIT && s)
        ir <= instr;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_WAIT:      if (s) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_mov_imm)                  state_nxt = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)   state_nxt = S_GET_B;
        else if (is_alu)                 state_nxt = S_GET_A;
        else                             state_nxt = S_ERR;
      end
      S_ERR:       state_nxt = S_WAIT;
      S_GET_A:     state_nxt = S_GET_B;
      S_GET_B:     state_nxt = S_EXEC;
      S_EXEC:      state_nxt = is_cmp ? S_WAIT : S_WRITE_RES;
      S_WRITE_RES: state_nxt = S_WAIT;
      S_WRITE_IMM: state_nxt = S_WAIT;
      default:     state_nxt = S_WAIT;
    endcase
  end

  // Moore outputs: depend only on state and IR, so reset forces them idle at once
  always_comb begin
    w        = 1'b0;
    err      = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    aluop    = 2'b00;
    unique case (state)
      S_WAIT:   w = 1'b1;
      S_DECODE: ;
      S_ERR:    err = 1'b1;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_EXEC: begin
        shift = sh;
        aluop = is_alu ? op : 2'b00;
        asel  = is_mov_reg || is_mvn;
        if (is_cmp) loads = 1'b1;
        else        loadc = 1'b1;
      end
      S_WRITE_RES: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
      end
      default: w = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: steps instructions one cycle at a time
// and compares the full control vector against hand-computed values.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        w, err, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8;

  int n_cmp = 0;
  int n_err = 0;

  regfile_sequencer #(.DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .instr(instr),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
    .sximm8(sximm8)
  );

  always #5 clk = ~clk;

  logic [20:0] ctl;
  assign ctl = {w, err, write, loada, loadb, loadc, loads, asel, bsel,
                vsel, shift, aluop, readnum, writenum};

  // {w,err,write,loada,loadb,loadc,loads,asel,bsel,vsel,shift,aluop,readnum,writenum}
  function automatic logic [20:0] ev(input logic w_e, input logic err_e,
                                     input logic wr_e, input logic la_e,
                                     input logic lb_e, input logic lc_e,
                                     input logic ls_e, input logic as_e,
                                     input logic [1:0] vs_e, input logic [1:0] sh_e,
                                     input logic [1:0] op_e, input logic [2:0] rn_e,
                                     input logic [2:0] wn_e);
    return {w_e, err_e, wr_e, la_e, lb_e, lc_e, ls_e, as_e, 1'b0,
            vs_e, sh_e, op_e, rn_e, wn_e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [20:0] IDLE, NONE;

  initial begin
    IDLE = ev(1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);
    NONE = ev(0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0);

    // reset state
    #3;
    chk("reset_ctl", 32'(ctl), 32'(IDLE));
    chk("reset_sximm8", 32'(sximm8), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // MOV R3,#-5
    s = 1'b1; instr = 16'hD3FB;
    tick(); s = 1'b0;
    chk("movi_decode", 32'(ctl), 32'(NONE));
    tick();
    chk("movi_write", 32'(ctl), 32'(ev(0,0,1,0,0,0,0,0,2'b10,2'b00,2'b00,3'd0,3'd3)));
    chk("movi_sximm8", 32'(sximm8), 32'hFFFB);
    tick();
    chk("movi_done", 32'(ctl), 32'(IDLE));

    // ADD R2,R1,R0 LSL#1
    @(negedge clk);
    s = 1'b1; instr = 16'hA148;
    tick(); s = 1'b0;
    chk("add_decode", 32'(ctl), 32'(NONE));
    tick();
    chk("add_get_a", 32'(ctl), 32'(ev(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd1,3'd0)));
    tick();
    chk("add_get_b", 32'(ctl), 32'(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0)));
    tick();
    chk("add_exec", 32'(ctl), 32'(ev(0,0,0,0,0,1,0,0,2'b00,2'b01,2'b00,3'd0,3'd0)));
    tick();
    chk("add_write", 32'(ctl), 32'(ev(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd2)));
    tick();
    chk("add_done", 32'(ctl), 32'(IDLE));

    // CMP R5,R6
    @(negedge clk);
    s = 1'b1; instr = 16'hAD06;
    tick(); s = 1'b0;
    chk("cmp_decode", 32'(ctl), 32'(NONE));
    tick();
    chk("cmp_get_a", 32'(ctl), 32'(ev(0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,3'd5,3'd0)));
    tick();
    chk("cmp_get_b", 32'(ctl), 32'(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd6,3'd0)));
    tick();
    chk("cmp_exec", 32'(ctl), 32'(ev(0,0,0,0,0,0,1,0,2'b00,2'b00,2'b01,3'd0,3'd0)));
    tick();
    chk("cmp_done", 32'(ctl), 32'(IDLE));

    // illegal, then MVN R7,R4 accepted back-to-back with s held high
    @(negedge clk);
    s = 1'b1; instr = 16'hE000;
    tick(); instr = 16'hB8E4;
    chk("ill_decode", 32'(ctl), 32'(NONE));
    tick();
    chk("ill_err", 32'(ctl), 32'(ev(0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0)));
    tick();
    chk("ill_done", 32'(ctl), 32'(IDLE));
    tick(); s = 1'b0;
    chk("mvn_decode", 32'(ctl), 32'(NONE));
    tick();
    chk("mvn_get_b", 32'(ctl), 32'(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd4,3'd0)));
    tick();
    chk("mvn_exec", 32'(ctl), 32'(ev(0,0,0,0,0,1,0,1,2'b00,2'b00,2'b11,3'd0,3'd0)));
    tick();
    chk("mvn_write", 32'(ctl), 32'(ev(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd7)));
    tick();
    chk("mvn_done", 32'(ctl), 32'(IDLE));

    // MOV R1,R2 LSR; s and instr disturbed while busy
    @(negedge clk);
    s = 1'b1; instr = 16'hC032;
    tick(); instr = 16'hD3FB;
    chk("movr_decode", 32'(ctl), 32'(NONE));
    tick(); s = 1'b0; instr = 16'hA148;
    chk("movr_get_b", 32'(ctl), 32'(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd2,3'd0)));
    tick(); s = 1'b1;
    chk("movr_exec", 32'(ctl), 32'(ev(0,0,0,0,0,1,0,1,2'b00,2'b10,2'b00,3'd0,3'd0)));
    tick(); s = 1'b0;
    chk("movr_write", 32'(ctl), 32'(ev(0,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd1)));
    tick();
    chk("movr_done", 32'(ctl), 32'(IDLE));
    tick();
    chk("movr_stay_idle", 32'(ctl), 32'(IDLE));

    // reset during GET_B of an ADD
    @(negedge clk);
    s = 1'b1; instr = 16'hA148;
    tick(); s = 1'b0;
    tick();
    tick();
    chk("rst_pre_get_b", 32'(ctl), 32'(ev(0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,3'd0,3'd0)));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctl", 32'(ctl), 32'(IDLE));
    chk("rst_async_ir", 32'(sximm8), 32'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_post_idle", 32'(ctl), 32'(IDLE));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle controller FSM directly upstream of the 8x16 register file. Drives `writenum`, `readnum` and `write`, plus load strobes and mux selects for the A/B/C/status registers, shifter and ALU downstream of `data_out`.
- Latches one 16-bit instruction per start handshake and sequences its register reads, execute step and writeback.
- Ends in the idle state with `w` high.

Parameters:
- DATA_W, 16: datapath width. Sets the width of `sximm8`. Must be at least 8.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- s  in  1  start; sampled only in WAIT.
- instr  in  16  instruction; captured into IR when s accepted.
- w  out  1  ready/idle; high only in WAIT.
- err  out  1  one-cycle pulse on illegal opcode.
- readnum  out  3  regfile read index.
- writenum  out  3  regfile write index.
- write  out  1  regfile write enable.
- loada  out  1  load enable, A register.
- loadb  out  1  load enable, B register.
- loadc  out  1  load enable, C register.
- loads  out  1  load enable, status register.
- asel  out  1  1 = ALU A-input forced to zero.
- bsel  out  1  1 = ALU B-input from sximm8 (always 0 in this block).
- vsel  out  2  writeback source: 00 = C, 10 = sximm8.
- shift  out  2  shifter op, equal to IR[4:3] in EXEC, else 00.
- aluop  out  2  00 ADD, 01 CMP(SUB), 10 AND, 11 MVN.
- sximm8  out  DATA_W  IR[7:0] sign-extended.

Behaviour:
- IR fields:
  - opcode = IR[15:13]
  - op = IR[12:11]
  - Rn = IR[10:8]
  - Rd = IR[7:5]
  - sh = IR[4:3]
  - Rm = IR[2:0]
- Legal instructions:
  - opcode 110, op 10: MOV Rn,#imm8
  - opcode 110, op 00: MOV Rd,Rm,sh
  - opcode 101, any op: ALU
  - anything else is illegal.
- Outputs are Moore: a function of state and IR only. Every strobe not listed for a state is 0; unlisted selects are 0.
- Reset (async, any state, including mid-instruction):
  - state = WAIT, IR = 0.
  - All strobes and err = 0, w = 1.
  - Any pending write is abandoned; no write strobe is produced.
- States and transitions:
  - WAIT: w=1. If s=1, IR <= instr and next state is DECODE; else stay. instr is ignored outside WAIT; s outside WAIT has no effect.
  - DECODE: no strobes. MOV imm -> WRITE_IMM; MOV reg -> GET_B; ALU MVN (op 11) -> GET_B; other ALU -> GET_A; illegal -> ERR.
  - ERR: err=1 for exactly one cycle -> WAIT. No regfile write.
  - GET_A: readnum=Rn, loada=1 -> GET_B.
  - GET_B: readnum=Rm, loadb=1 -> EXEC.
  - EXEC:
    - shift=sh.
    - aluop=op for ALU, 00 for MOV reg.
    - asel=1 for MOV reg and MVN, else 0.
    - CMP: loads=1 -> WAIT, no writeback.
    - Otherwise: loadc=1 -> WRITE_RES.
  - WRITE_RES: writenum=Rd, vsel=00, write=1 -> WAIT.
  - WRITE_IMM: writenum=Rn, vsel=10, write=1 -> WAIT.
- Latency, counted from the edge that accepts s to w high again:
  - MOV imm: 3 cycles.
  - MOV reg and MVN: 5 cycles.
  - ADD and AND: 6 cycles.
  - CMP: 5 cycles.
  - Illegal: 3 cycles.
- Back-to-back: if s=1 on the first cycle w=1, the next instruction is accepted immediately. No bubble beyond WAIT.
- write is asserted for exactly one cycle per writing instruction and never together with loada, loadb, loadc or loads.
- Source and destination registers may alias (Rd = Rn = Rm). The sequencing order guarantees reads complete before the write.
- readnum and writenum hold 000 in states where they are unused.

Test Plan:
1. Reset mid-op: assert rst_n=0 during GET_B of an ADD -> w=1 and all strobes 0 immediately (asynchronously); no write occurs after release.
2. MOV R3,#-5 (instr 0xD3FB) -> exactly 3 cycles after accept: one-cycle write=1, writenum=3, vsel=10, sximm8=0xFFFB; then w=1.
3. ADD R2,R1,R0 LSL#1 (instr 0xA148) -> cycle sequence:
   - GET_A: loada with readnum=1.
   - GET_B: loadb with readnum=0.
   - EXEC: loadc, shift=01, aluop=00, asel=0.
   - WRITE_RES: write with writenum=2.
   - w=1 after 6 cycles.
4. CMP R5,R6 (instr 0xAD06) -> loads=1 in EXEC with aluop=01; write never asserted; w returns after 5 cycles.
5. Illegal instr 0xE000 -> err pulses high for exactly 1 cycle; no strobes; w=1 3 cycles after accept. Then s held high with MVN R7,R4 (instr 0xB8E4) accepted on the first w=1 cycle -> asel=1 and aluop=11 in EXEC, write with writenum=7.
6. s pulsed while busy, and instr changed mid-instruction -> IR unaffected; only the originally accepted instruction executes.
